// File: rtl/uart_rx.sv
// UART receiver: 2-flop synced rx, mid-bit sampling, 8N1 LSB-first, or 8E1 when UART_RX_PARITY_EN is defined.
// Strobes land on the clk edge of the stop-bit sample tick. There is no backpressure: the consumer must take each byte on its data_valid pulse.
module uart_rx #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_tick,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] HALF_M1 = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_M1 = TW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_t;

    state_t        state, state_nxt;
    logic          rx_meta, rx_s;
    logic [TW-1:0] tick_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    sr;
    logic          tick_clr, tick_inc, bit_clr, shift_en, par_cap, stop_smp;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Everything except the synchronizer advances only on rx_tick.
    always_comb begin
        state_nxt = state;
        tick_clr  = 1'b0;
        tick_inc  = 1'b0;
        bit_clr   = 1'b0;
        shift_en  = 1'b0;
        par_cap   = 1'b0;
        stop_smp  = 1'b0;
        if (rx_tick) begin
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        tick_clr  = 1'b1;
                        state_nxt = START;
                    end
                end
                START: begin
                    if (tick_cnt == HALF_M1) begin
                        tick_clr = 1'b1;
                        if (rx_s) begin
                            state_nxt = IDLE;
                        end else begin
                            bit_clr   = 1'b1;
                            state_nxt = DATA;
                        end
                    end else begin
                        tick_inc = 1'b1;
                    end
                end
                DATA: begin
                    if (tick_cnt == FULL_M1) begin
                        tick_clr = 1'b1;
                        shift_en = 1'b1;
                        if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_nxt = PARITY;
`else
                            state_nxt = STOP;
`endif
                        end
                    end else begin
                        tick_inc = 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tick_cnt == FULL_M1) begin
                        tick_clr  = 1'b1;
                        par_cap   = 1'b1;
                        state_nxt = STOP;
                    end else begin
                        tick_inc = 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (tick_cnt == FULL_M1) begin
                        tick_clr  = 1'b1;
                        stop_smp  = 1'b1;
                        state_nxt = rx_s ? IDLE : BREAK;
                    end else begin
                        tick_inc = 1'b1;
                    end
                end
                BREAK: begin
                    if (rx_s) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt   <= '0;
            bit_cnt    <= 3'd0;
            sr         <= 8'h00;
            data_out   <= 8'h00;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            if (tick_clr)      tick_cnt <= '0;
            else if (tick_inc) tick_cnt <= tick_cnt + 1'b1;
            if (bit_clr)       bit_cnt <= 3'd0;
            else if (shift_en) bit_cnt <= bit_cnt + 3'd1;
            if (shift_en)      sr <= {rx_s, sr[7:1]};
            if (stop_smp)      data_out <= sr;
            data_valid <= stop_smp & rx_s;
            frame_err  <= stop_smp & ~rx_s;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_bit;

    always_ff @(posedge clk) begin
        if (rst) begin
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (par_cap) par_bit <= rx_s;
            // Even parity: data bits plus parity bit must XOR to zero.
            parity_err <= stop_smp & rx_s & (^{sr, par_bit});
        end
    end
`else
    assign parity_err = 1'b0;
`endif

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized frames for uart_rx; every strobe is logged and compared to an event list built from the frames sent.
`timescale 1ns/1ps
module tb_uart_rx;
    localparam int OS = 16;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_tick;
    logic       rx;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       parity_err;
    logic       busy;

    int n_cmp  = 0;
    int n_fail = 0;
    int period = 4;
    int tcnt   = 0;

    // Event word: {parity_err, frame_err, data_valid, data_out}
    logic [10:0] got_q[$];
    logic [10:0] exp_q[$];

    uart_rx #(.OVERSAMPLE(OS)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_tick    (rx_tick),
        .rx         (rx),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        rx_tick = 1'b0;
        forever begin
            @(negedge clk);
            tcnt++;
            if (tcnt >= period) tcnt = 0;
            rx_tick = (tcnt == 0);
        end
    end

    always @(negedge clk) begin
        if (data_valid || frame_err || parity_err)
            got_q.push_back({parity_err, frame_err, data_valid, data_out});
    end

    function automatic logic [10:0] model(logic [7:0] d, logic par, logic stp);
        if (!stp) return {1'b0, 1'b1, 1'b0, d};
        return {PAR & (^d ^ par), 1'b0, 1'b1, d};
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_events(string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check({tag, "_event"}, {21'd0, got_q[i]}, {21'd0, exp_q[i]});
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_clk(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(logic b);
        rx = b;
        wait_clk(OS * period);
    endtask

    task automatic send_frame(logic [7:0] d, logic par, logic stp);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (PAR) send_bit(par);
        send_bit(stp);
    endtask

    task automatic frame(logic [7:0] d, logic stp);
        exp_q.push_back(model(d, ^d, stp));
        send_frame(d, ^d, stp);
    endtask

    initial begin
        logic [7:0] d;
        logic       par, stp;

        rst = 1'b1;
        rx  = 1'b1;
        wait_clk(5);
        check("rst_data_out", data_out, 8'h00);
        check("rst_data_valid", data_valid, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_parity_err", parity_err, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst = 1'b0;
        wait_clk(OS * period);

        frame(8'hA5, 1'b1);
        wait_clk(4 * period);
        check_events("a5");
        check("a5_data_out", data_out, 8'hA5);
        check("a5_busy", busy, 1'b0);

        // Short low pulse: start bit is rejected at its centre.
        rx = 1'b0;
        wait_clk(5 * period);
        check("glitch_busy_mid", busy, 1'b1);
        rx = 1'b1;
        wait_clk(2 * OS * period);
        check_events("glitch");
        check("glitch_busy", busy, 1'b0);
        check("glitch_data_out", data_out, 8'hA5);

        frame(8'h3C, 1'b0);
        wait_clk(2 * OS * period);
        check("brk_busy_low", busy, 1'b1);
        check_events("ferr");
        check("ferr_data_out", data_out, 8'h3C);
        rx = 1'b1;
        wait_clk(3 * period + 4);
        check("brk_busy_release", busy, 1'b0);
        wait_clk(OS * period);
        check_events("brk_quiet");

        frame(8'h00, 1'b1);
        frame(8'hFF, 1'b1);
        frame(8'h81, 1'b1);
        wait_clk(OS * period);
        check_events("b2b");
        check("b2b_data_out", data_out, 8'h81);

        d = 8'h55;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i]);
        rx = d[4];
        wait_clk(OS * period / 2);
        rst = 1'b1;
        wait_clk(1);
        rst = 1'b0;
        rx  = 1'b1;
        check("abort_busy", busy, 1'b0);
        check("abort_data_out", data_out, 8'h00);
        wait_clk(2 * OS * period);
        check_events("abort");
        frame(8'h12, 1'b1);
        wait_clk(OS * period);
        check_events("post_abort");
        check("post_abort_data_out", data_out, 8'h12);

`ifdef UART_RX_PARITY_EN
        exp_q.push_back(model(8'h07, 1'b1, 1'b1));
        send_frame(8'h07, 1'b1, 1'b1);
        exp_q.push_back(model(8'h07, 1'b0, 1'b1));
        send_frame(8'h07, 1'b0, 1'b1);
        wait_clk(OS * period);
        check_events("parity");
`endif

        for (int n = 0; n < 16; n++) begin
            period = $urandom_range(3, 6);
            d      = 8'($urandom);
            par    = 1'($urandom);
            stp    = ($urandom_range(0, 3) != 0);
            exp_q.push_back(model(d, par, stp));
            send_frame(d, par, stp);
            if (!stp) begin
                wait_clk($urandom_range(1, 3) * OS * period);
                rx = 1'b1;
                wait_clk(2 * period + 4);
            end
            wait_clk($urandom_range(0, 2) * OS * period);
        end
        rx = 1'b1;
        wait_clk(2 * OS * period);
        check_events("rand");
        check("rand_busy", busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
# uart_rx

Serial-to-parallel UART receiver: the receive-side counterpart of the transmit PISO shifter. It oversamples the incoming serial line using an external baud-rate tick and validates the start bit at mid-bit. It reassembles 8 data bits LSB-first, checks the stop bit (and optionally even parity), and presents the byte with a one-cycle valid strobe. It sits between the board-level RX pin and the receive-side byte consumer (FIFO or register interface).

## Interface
Parameters:
- OVERSAMPLE, 16, `rx_tick` pulses per bit period; even, 4..64.

Ports:
- clk  input  1  system clock; every register is clocked on its rising edge.
- rst  input  1  synchronous, active-high reset.
- rx_tick  input  1  single-cycle enable at OVERSAMPLE × baud rate, from the baud generator.
- rx  input  1  asynchronous serial line; idles high.
- data_out  output  8  last received byte; holds its value until the next frame completes.
- data_valid  output  1  one-cycle pulse when a good frame has completed.
- frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
- parity_err  output  1  one-cycle pulse on parity mismatch; tied 0 when parity is compiled out.
- busy  output  1  high in every state except IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer, reset to 1. All logic uses the synchronized value `rx_s`.
- Counters:
  - `tick_cnt`, width clog2(OVERSAMPLE), advances only on `rx_tick`.
  - `bit_cnt`, 3 bits.
- Shift register: `sr <= {rx_s, sr[7:1]}` (LSB-first, shifting right).
- FSM states:
  - IDLE: wait for `rx_s`==0 on an `rx_tick`, then clear `tick_cnt` and go to START.
  - START: when `tick_cnt` reaches OVERSAMPLE/2−1, check `rx_s`. If 0, clear `tick_cnt` and `bit_cnt` and go to DATA. If 1, treat it as a glitch and return to IDLE with no output pulse.
  - DATA: on each `tick_cnt` reaching OVERSAMPLE−1, shift in `rx_s` and increment `bit_cnt`. After bit 7, go to PARITY if parity is enabled, otherwise STOP.
  - PARITY: at bit centre, capture `rx_s` into `par_bit`, then go to STOP.
  - STOP: at bit centre, load `data_out <= sr`.
    - If `rx_s`==1: pulse `data_valid` (and `parity_err` on mismatch), then go to IDLE.
    - If `rx_s`==0: pulse `frame_err` only, with no `data_valid`, then go to BREAK.
  - BREAK: wait for `rx_s`==1, then go to IDLE. This prevents a held-low line from being read as repeated frames.
- The parity check uses even parity: XOR of the 8 data bits and `par_bit` must equal 0.
- On a parity error, `data_valid` still pulses together with `parity_err`. The consumer decides whether to discard the byte.
- `data_out` is not updated on a glitch rejection.

## Timing
- Reset values:
  - `data_out`=0x00; `data_valid`, `frame_err`, `parity_err` = 0; `busy`=0.
  - State is IDLE; counters are 0; synchronizer flops are 1.
- Reset mid-frame aborts the frame: no pulse is produced and `data_out` keeps its reset value of 0x00.
- `rx_tick` low freezes the FSM and counters, except for the synchronizer.
- Input latency: an `rx` edge is visible on `rx_s` 2 clk later.
- Sample points fall at OVERSAMPLE/2 ticks after the detected falling edge, then every OVERSAMPLE ticks.
- Output strobes:
  - `data_out`, `data_valid`, `frame_err` and `parity_err` update on the clk edge of the stop-bit sample tick.
  - Each strobe is high for exactly one clk, independent of `rx_tick` spacing.
- Back-to-back frames: IDLE is re-entered at mid-stop-bit. A start edge arriving half a bit later is detected with no lost frame.
- `busy` rises the cycle after the start edge is detected. It falls in the same cycle as the strobe, or when BREAK or a glitch rejection exits to IDLE.

## Configuration
- `UART_RX_PARITY_EN`:
  - Defined: the PARITY state exists and a frame is start + 8 data + even parity + stop (11 bits).
  - Undefined: the PARITY state is removed, a frame is 10 bits, and `parity_err` is constant 0.

## Test plan
- OVERSAMPLE=16, `rx_tick` every 4 clk, frame 0xA5 with stop=1 -> `data_out`=0xA5, one `data_valid` pulse, `frame_err`=0, `busy` low afterwards.
- Low pulse on `rx` of 5 ticks (< OVERSAMPLE/2) -> START rejects it, FSM returns to IDLE, no strobes, `data_out` unchanged.
- Frame 0x3C with stop bit driven 0, line held low 3 bit times -> one `frame_err` pulse, no `data_valid`, `data_out`=0x3C, `busy` stays high until `rx` returns high, and no further frames are decoded.
- Frames 0x00, 0xFF, 0x81 sent with zero idle gap -> exactly three `data_valid` pulses with matching `data_out` values.
- `rst` asserted for 1 clk during data bit 4 of 0x55, then a clean frame 0x12 -> no strobe for the aborted frame, then `data_out`=0x12 with a `data_valid` pulse.
- With `UART_RX_PARITY_EN`: 0x07 with parity bit 1 -> `data_valid`=1, `parity_err`=0. 0x07 with parity bit 0 -> `data_valid` and `parity_err` both pulse.
